// File: rtl/vector_reduce_accumulate_unit_pkg.sv
// ---------------------------------------------------------------------------
// vrau_pkg
// Shared definitions for the vector reduce / accumulate stage.
//   vrau_mode_t  : per-chain firmware mode codes (unknown codes act as PASS)
//   CHAIN_W      : chain id width for the default chain count
// ---------------------------------------------------------------------------
package vrau_pkg;

    typedef enum logic [7:0] {
        MODE_PASS      = 8'd0,
        MODE_SUM       = 8'd1,
        MODE_MAX       = 8'd2,
        MODE_MIN       = 8'd3,
        MODE_FRAME_SUM = 8'd4
    } vrau_mode_t;

    localparam int unsigned DEFAULT_MAX_CHAINS = 4;
    localparam int unsigned CHAIN_W            = $clog2(DEFAULT_MAX_CHAINS);

endpackage

// File: rtl/vector_reduce_accumulate_unit_tree.sv
// ---------------------------------------------------------------------------
// vector_reduce_tree
// Combinational reduction of an N-lane vector.
//   vector : N lanes of DATA_WIDTH, two's complement
//   sum    : lane sum, wraps modulo 2^DATA_WIDTH
//   smax   : signed maximum lane
//   smin   : signed minimum lane
// ---------------------------------------------------------------------------
module vector_reduce_tree #(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [N-1:0][DATA_WIDTH-1:0] vector,
    output logic [DATA_WIDTH-1:0]        sum,
    output logic [DATA_WIDTH-1:0]        smax,
    output logic [DATA_WIDTH-1:0]        smin
);

    // Heap-ordered binary tree: leaves at N..2N-1, root at 1, slot 0 unused.
    logic [DATA_WIDTH-1:0] sum_node [2*N];
    logic [DATA_WIDTH-1:0] max_node [2*N];
    logic [DATA_WIDTH-1:0] min_node [2*N];

    always_comb begin
        sum_node[0] = '0;
        max_node[0] = '0;
        min_node[0] = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum_node[N+i] = vector[i];
            max_node[N+i] = vector[i];
            min_node[N+i] = vector[i];
        end
        for (int unsigned i = N - 1; i >= 1; i--) begin
            sum_node[i] = sum_node[2*i] + sum_node[2*i+1];
            max_node[i] = ($signed(max_node[2*i]) > $signed(max_node[2*i+1]))
                          ? max_node[2*i] : max_node[2*i+1];
            min_node[i] = ($signed(min_node[2*i]) < $signed(min_node[2*i+1]))
                          ? min_node[2*i] : min_node[2*i+1];
        end
    end

    assign sum  = sum_node[1];
    assign smax = max_node[1];
    assign smin = min_node[1];

endmodule

// File: rtl/vector_reduce_accumulate_unit.sv
// ---------------------------------------------------------------------------
// vector_reduce_accumulate_unit
// Per-chain configurable reduction stage: PASS / SUM / MAX / MIN / FRAME_SUM.
// Two-cycle fixed latency, one vector per cycle, no backpressure.
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_in              : input vector valid (ignored while tracing==0)
//   bof_in, eof_in        : frame delimiters, travel with the data
//   chainId_in            : chain selecting mode and accumulator
//   tracing               : 1 = process, 0 = configure
//   configId, configData  : mode write (only while tracing==0)
//   vector_in             : N lanes of DATA_WIDTH
//   valid_out, vector_out : result
//   bof_out, eof_out, chainId_out : delimiters / chain delayed by 2 cycles
// ---------------------------------------------------------------------------
module vector_reduce_accumulate_unit
    import vrau_pkg::*;
#(
    parameter int unsigned                N                  = 8,
    parameter int unsigned                DATA_WIDTH         = 32,
    parameter int unsigned                MAX_CHAINS         = 4,
    parameter int unsigned                PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE   = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic                             bof_in,
    input  logic                             eof_in,
    input  logic [$clog2(MAX_CHAINS)-1:0]    chainId_in,
    input  logic                             tracing,
    input  logic [7:0]                       configId,
    input  logic [7:0]                       configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
    output logic                             valid_out,
    output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
    output logic                             bof_out,
    output logic                             eof_out,
    output logic [$clog2(MAX_CHAINS)-1:0]    chainId_out
);

    localparam int unsigned CW = $clog2(MAX_CHAINS);

    logic [MAX_CHAINS-1:0][7:0]            fw;
    logic [MAX_CHAINS-1:0][DATA_WIDTH-1:0] acc;

    // Configuration decode. The unsigned subtraction wraps ids below the
    // window to huge values, so one compare covers both bounds.
    logic [31:0]   cfg_off;
    logic          cfg_hit;
    logic [CW-1:0] cfg_idx;

    assign cfg_off = 32'(configId) - PERSONAL_CONFIG_ID;
    assign cfg_hit = !tracing && (cfg_off < MAX_CHAINS);
    assign cfg_idx = cfg_off[CW-1:0];

    logic [DATA_WIDTH-1:0] tree_sum, tree_max, tree_min;

    vector_reduce_tree #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tree (
        .vector (vector_in),
        .sum    (tree_sum),
        .smax   (tree_max),
        .smin   (tree_min)
    );

    // Stage 1
    logic [DATA_WIDTH-1:0]        s1_sum, s1_max, s1_min;
    logic [N-1:0][DATA_WIDTH-1:0] s1_vec;
    logic                         s1_valid, s1_bof, s1_eof;
    logic [CW-1:0]                s1_chain;
    logic [7:0]                   s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_sum   <= '0;
            s1_max   <= '0;
            s1_min   <= '0;
            s1_vec   <= '0;
            s1_valid <= 1'b0;
            s1_bof   <= 1'b0;
            s1_eof   <= 1'b0;
            s1_chain <= '0;
            s1_mode  <= '0;
        end else begin
            s1_sum   <= tree_sum;
            s1_max   <= tree_max;
            s1_min   <= tree_min;
            s1_vec   <= vector_in;
            s1_valid <= valid_in && tracing;
            s1_bof   <= bof_in;
            s1_eof   <= eof_in;
            s1_chain <= chainId_in;
            s1_mode  <= fw[chainId_in];
        end
    end

    // Stage 2 next-state. The accumulator is read and written in the same
    // stage, so a back-to-back vector of the same chain always sees the
    // value committed on the previous edge; no bypass path is needed.
    logic [DATA_WIDTH-1:0]        acc_base, acc_next;
    logic [N-1:0][DATA_WIDTH-1:0] nxt_vec;
    logic                         nxt_valid;
    logic                         acc_we;

    always_comb begin
        acc_base  = s1_bof ? '0 : acc[s1_chain];
        acc_next  = acc_base + s1_sum;
        nxt_valid = s1_valid;
        nxt_vec   = vector_out;
        acc_we    = 1'b0;
        case (s1_mode)
            MODE_SUM: begin
                nxt_vec    = '0;
                nxt_vec[0] = s1_sum;
            end
            MODE_MAX: begin
                nxt_vec    = '0;
                nxt_vec[0] = s1_max;
            end
            MODE_MIN: begin
                nxt_vec    = '0;
                nxt_vec[0] = s1_min;
            end
            MODE_FRAME_SUM: begin
                acc_we    = s1_valid;
                nxt_valid = s1_valid && s1_eof;
                if (s1_valid && s1_eof) begin
                    nxt_vec    = '0;
                    nxt_vec[0] = acc_next;
                end
            end
            default: begin
                nxt_vec = s1_vec;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out   <= 1'b0;
            vector_out  <= '0;
            bof_out     <= 1'b0;
            eof_out     <= 1'b0;
            chainId_out <= '0;
        end else begin
            valid_out   <= nxt_valid;
            vector_out  <= nxt_vec;
            bof_out     <= s1_bof;
            eof_out     <= s1_eof;
            chainId_out <= s1_chain;
        end
    end

    // Firmware and accumulators. A mode write clears its chain's accumulator
    // and takes priority over a same-edge accumulation from a draining vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw  <= INITIAL_FIRMWARE;
            acc <= '0;
        end else begin
            if (acc_we) begin
                acc[s1_chain] <= acc_next;
            end
            if (cfg_hit) begin
                fw[cfg_idx]  <= configData;
                acc[cfg_idx] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vector_reduce_accumulate_unit.sv
module tb_vector_reduce_accumulate_unit;

    localparam int unsigned N   = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned MC  = 4;
    localparam int unsigned PCI = 16;
    // chain3 = MAX, chain2 = FRAME_SUM, chains 1/0 = PASS
    localparam logic [MC-1:0][7:0] INIT = 32'h0204_0000;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic       clk;
    logic       rst_n;
    logic       valid_in, bof_in, eof_in, tracing;
    logic [1:0] chainId_in;
    logic [7:0] configId, configData;
    vec_t       vector_in;
    logic       valid_out, bof_out, eof_out;
    vec_t       vector_out;
    logic [1:0] chainId_out;

    int errors = 0;
    int checks = 0;

    vector_reduce_accumulate_unit #(
        .N                  (N),
        .DATA_WIDTH         (DW),
        .MAX_CHAINS         (MC),
        .PERSONAL_CONFIG_ID (PCI),
        .INITIAL_FIRMWARE   (INIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .bof_in      (bof_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .valid_out   (valid_out),
        .vector_out  (vector_out),
        .bof_out     (bof_out),
        .eof_out     (eof_out),
        .chainId_out (chainId_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic tr, input logic v, input logic b, input logic e,
                         input logic [1:0] ch, input vec_t vec,
                         input logic [7:0] cid, input logic [7:0] cdata);
        tracing    = tr;
        valid_in   = v;
        bof_in     = b;
        eof_in     = e;
        chainId_in = ch;
        vector_in  = vec;
        configId   = cid;
        configData = cdata;
        tick();
    endtask

    task automatic send(input logic tr, input logic v, input logic b, input logic e,
                        input logic [1:0] ch, input vec_t vec);
        drive(tr, v, b, e, ch, vec, 8'hFF, 8'h00);
    endtask

    task automatic cfg(input logic [7:0] id, input logic [7:0] data);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, id, data);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 8'hFF, 8'h00);
    endtask

    function automatic vec_t lane0(input logic [DW-1:0] val);
        vec_t r;
        r    = '0;
        r[0] = val;
        return r;
    endfunction

    // Behavioural reference model: per-input expected result, compared two
    // cycles later.
    typedef struct {
        logic       valid;
        logic       bof;
        logic       eof;
        logic [1:0] chain;
        vec_t       vec;
    } exp_t;

    exp_t         q[$];
    logic [7:0]   m_fw[MC];
    logic [DW-1:0] m_acc[MC];

    task automatic model_push(input logic tr, input logic v, input logic b, input logic e,
                              input logic [1:0] ch, input vec_t vec,
                              input logic [7:0] cid, input logic [7:0] cdata);
        exp_t x;
        logic [DW-1:0] s;
        logic signed [DW-1:0] mx, mn;
        int unsigned idx;
        x.valid = 1'b0;
        x.vec   = '0;
        x.bof   = b;
        x.eof   = e;
        x.chain = ch;
        s  = '0;
        mx = vec[0];
        mn = vec[0];
        for (int l = 0; l < N; l++) begin
            s += vec[l];
            if ($signed(vec[l]) > mx) mx = vec[l];
            if ($signed(vec[l]) < mn) mn = vec[l];
        end
        if (tr && v) begin
            case (m_fw[ch])
                8'd1: begin x.valid = 1'b1; x.vec[0] = s; end
                8'd2: begin x.valid = 1'b1; x.vec[0] = mx; end
                8'd3: begin x.valid = 1'b1; x.vec[0] = mn; end
                8'd4: begin
                    if (b) m_acc[ch] = '0;
                    m_acc[ch] = m_acc[ch] + s;
                    if (e) begin
                        x.valid  = 1'b1;
                        x.vec[0] = m_acc[ch];
                    end
                end
                default: begin x.valid = 1'b1; x.vec = vec; end
            endcase
        end
        if (!tr && cid >= PCI && cid < PCI + MC) begin
            idx        = cid - PCI;
            m_fw[idx]  = cdata;
            m_acc[idx] = '0;
        end
        q.push_back(x);
    endtask

    task automatic compare_front();
        exp_t x;
        x = q.pop_front();
        chk("rnd_valid", valid_out, x.valid);
        if (x.valid) chk("rnd_vec", vector_out, x.vec);
        chk("rnd_bof", bof_out, x.bof);
        chk("rnd_eof", eof_out, x.eof);
        chk("rnd_chain", chainId_out, x.chain);
    endtask

    typedef struct {
        logic [7:0] mode;
        logic       b;
        logic       e;
        vec_t       vec;
        logic       exp_valid;
        vec_t       exp_vec;
    } tv_t;

    tv_t tbl[9];

    initial begin
        vec_t v18, vmix, vbig, vp, ones, rv;
        int   mix[8];
        logic [MC-1:0][7:0] init_v;
        logic tr, v, b, e;
        logic [1:0] ch;
        logic [7:0] cid, cdata;

        mix = '{-5, 3, 7, -9, 0, 2, 1, 4};
        for (int i = 0; i < N; i++) begin
            v18[i]  = DW'(i + 1);
            vmix[i] = DW'(mix[i]);
            vbig[i] = 32'h7FFF_FFFF;
            vp[i]   = 32'hA5A5_0000 | DW'(i);
            ones[i] = 32'd1;
        end

        tbl[0] = '{8'd1, 1'b0, 1'b0, v18,  1'b1, lane0(32'd36)};
        tbl[1] = '{8'd2, 1'b0, 1'b0, vmix, 1'b1, lane0(32'd7)};
        tbl[2] = '{8'd3, 1'b0, 1'b0, vmix, 1'b1, lane0(32'hFFFF_FFF7)};
        tbl[3] = '{8'd1, 1'b0, 1'b0, vbig, 1'b1, lane0(32'hFFFF_FFF8)};
        tbl[4] = '{8'd0, 1'b0, 1'b0, vp,   1'b1, vp};
        tbl[5] = '{8'd7, 1'b0, 1'b0, vp,   1'b1, vp};
        tbl[6] = '{8'd4, 1'b1, 1'b1, v18,  1'b1, lane0(32'd36)};
        tbl[7] = '{8'd4, 1'b0, 1'b1, v18,  1'b1, lane0(32'd36)};
        tbl[8] = '{8'd4, 1'b0, 1'b0, v18,  1'b0, lane0(32'd36)};

        rst_n      = 1'b0;
        tracing    = 1'b1;
        valid_in   = 1'b0;
        bof_in     = 1'b0;
        eof_in     = 1'b0;
        chainId_in = '0;
        vector_in  = '0;
        configId   = 8'hFF;
        configData = 8'h00;

        #3;
        chk("reset_valid", valid_out, 1'b0);
        chk("reset_vec", vector_out, '0);
        chk("reset_bof", bof_out, 1'b0);
        chk("reset_eof", eof_out, 1'b0);
        chk("reset_chain", chainId_out, 2'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Table: configure chain 0, push one vector, check two cycles later.
        for (int i = 0; i < 9; i++) begin
            cfg(8'(PCI), tbl[i].mode);
            send(1'b1, 1'b1, tbl[i].b, tbl[i].e, 2'd0, tbl[i].vec);
            idle();
            chk($sformatf("tbl%0d_valid", i), valid_out, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_vec", i), vector_out, tbl[i].exp_vec);
        end

        // Frame sum on chain 1 with an interleaved chain-0 PASS vector.
        cfg(8'(PCI + 1), 8'd4);
        cfg(8'(PCI), 8'd0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, ones);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, vp);
        chk("frm_first_valid", valid_out, 1'b0);
        chk("frm_first_chain", chainId_out, 2'd1);
        chk("frm_first_bof", bof_out, 1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, ones);
        chk("frm_pass_valid", valid_out, 1'b1);
        chk("frm_pass_vec", vector_out, vp);
        send(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, ones);
        chk("frm_mid_valid", valid_out, 1'b0);
        chk("frm_mid_hold", vector_out, vp);
        idle();
        chk("frm_eof_valid", valid_out, 1'b1);
        chk("frm_eof_vec", vector_out, lane0(32'd24));
        chk("frm_eof_flag", eof_out, 1'b1);
        chk("frm_eof_chain", chainId_out, 2'd1);

        // Configuration window and tracing==0 behaviour.
        cfg(8'(PCI), 8'd0);
        cfg(8'(PCI + 2), 8'd1);
        send(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, v18);
        idle();
        chk("cfg_notrace_valid", valid_out, 1'b0);
        chk("cfg_notrace_chain", chainId_out, 2'd2);
        cfg(8'(PCI + MC), 8'd1);
        cfg(8'(PCI - 1), 8'd1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, v18);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, vp);
        chk("cfg_sum_valid", valid_out, 1'b1);
        chk("cfg_sum_vec", vector_out, lane0(32'd36));
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, vmix);
        chk("cfg_oor_hi_vec", vector_out, vp);
        idle();
        chk("cfg_oor_lo_vec", vector_out, lane0(32'd7));

        // Mid-frame reset on chain 2.
        cfg(8'(PCI + 2), 8'd4);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, vp);
        send(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, ones);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, ones);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", valid_out, 1'b0);
        chk("rst_async_vec", vector_out, '0);
        chk("rst_async_chain", chainId_out, 2'd0);
        chk("rst_async_bof", bof_out, 1'b0);
        idle();
        rst_n = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, ones);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, vp);
        chk("rst_frame_valid", valid_out, 1'b1);
        chk("rst_frame_vec", vector_out, lane0(32'd8));
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'd3, vmix);
        chk("rst_fw_pass_vec", vector_out, vp);
        idle();
        chk("rst_fw_max_vec", vector_out, lane0(32'd7));

        // Randomized run against the reference model.
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        init_v = INIT;
        for (int c = 0; c < MC; c++) begin
            m_fw[c]  = init_v[c];
            m_acc[c] = '0;
        end
        q.delete();
        for (int k = 0; k < 400; k++) begin
            tr    = ($urandom_range(0, 9) != 0);
            v     = ($urandom_range(0, 3) != 0);
            b     = ($urandom_range(0, 3) == 0);
            e     = ($urandom_range(0, 3) == 0);
            ch    = 2'($urandom_range(0, MC - 1));
            cid   = 8'($urandom_range(PCI - 2, PCI + MC + 1));
            cdata = 8'($urandom_range(0, 6));
            for (int l = 0; l < N; l++) begin
                if ($urandom_range(0, 1) == 1) rv[l] = $urandom;
                else rv[l] = DW'(int'($urandom_range(0, 40)) - 20);
            end
            model_push(tr, v, b, e, ch, rv, cid, cdata);
            drive(tr, v, b, e, ch, rv, cid, cdata);
            if (q.size() == 2) compare_front();
        end
        for (int k = 0; k < 2; k++) begin
            model_push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 8'hFF, 8'h00);
            idle();
            if (q.size() == 2) compare_front();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
